// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending unit.
package irq_pkg;
  localparam int NUM_INT = 16;
  localparam int ID_W    = $clog2(NUM_INT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_pending_unit_if.sv
// Controller-side handshake bundle: pending flags, request/id, ack and
// end-of-routine, in-service status.
interface irq_pending_unit_if #(
  parameter int NUM_INT = irq_pkg::NUM_INT,
  parameter int ID_W    = irq_pkg::ID_W
);
  logic [NUM_INT-1:0] ifr_out;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               in_service;
  logic               ack;
  logic               end_routine;

  // unit side
  modport master (
    output ifr_out, irq_req, irq_id, in_service,
    input  ack, end_routine
  );

  // interrupt controller side
  modport slave (
    input  ifr_out, irq_req, irq_id, in_service,
    output ack, end_routine
  );
endinterface

// File: rtl/irq_sync.sv
// Per-line 2-flop synchronizer plus a history flop used for rising-edge detect.
module irq_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] hist
);
  logic [W-1:0] meta;

  // meta -> sync resolves metastability; hist is sync delayed by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      hist <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end
endmodule

// File: rtl/irq_pending_unit.sv
// Interrupt pending unit: synchronizes raw lines, keeps the pending-flag
// register, picks the lowest-index eligible line and runs the
// request/service handshake with the interrupt controller.
module irq_pending_unit #(
  parameter int NUM_INT = irq_pkg::NUM_INT,
  parameter int ID_W    = $clog2(NUM_INT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] irq_in,
  input  logic [NUM_INT-1:0] edge_mode,
  input  logic [NUM_INT-1:0] ier_mask,
  input  logic               global_en,
  input  logic [NUM_INT-1:0] sw_clr,
  irq_pending_unit_if.master ctl
);
  import irq_pkg::*;

  logic [NUM_INT-1:0] sync, hist;
  logic [NUM_INT-1:0] ifr_q, ifr_nxt;
  logic [NUM_INT-1:0] rise, clr, ack_clr, elig;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    id_q, id_nxt;
  logic               req_q, req_nxt;
  logic               svc_q, svc_nxt;
  logic               ack_take;
  irq_state_e         state, state_nxt;

  irq_sync #(.W(NUM_INT)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (irq_in),
    .sync (sync),
    .hist (hist)
  );

  // ack only counts while a request is outstanding; it clears that line's edge flag
  assign ack_take = (state == REQUEST) && ctl.ack;
  assign ack_clr  = ack_take ? (NUM_INT'(1) << id_q) : '0;
  assign rise     = sync & ~hist;
  assign clr      = sw_clr | ack_clr;
  assign elig     = ifr_q & ier_mask & {NUM_INT{global_en}};

  // edge lines: sticky flag, set beats clear; level lines: registered level
  always_comb begin
    ifr_nxt = (edge_mode & (rise | (ifr_q & ~clr))) | (~edge_mode & sync);
  end

  // pending-flag register
  always_ff @(posedge clk) begin
    if (rst) ifr_q <= '0;
    else     ifr_q <= ifr_nxt;
  end

  // fixed priority: scan downward so the lowest eligible index is kept
  always_comb begin
    win_id = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  // FSM next state and next registered outputs
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    svc_nxt   = svc_q;
    id_nxt    = id_q;
    case (state)
      IDLE: begin
        if (|elig) begin
          state_nxt = REQUEST;
          req_nxt   = 1'b1;
          id_nxt    = win_id;
        end
      end
      REQUEST: begin
        // ack beats withdrawal; the id is frozen for the whole request
        if (ctl.ack) begin
          state_nxt = SERVICE;
          req_nxt   = 1'b0;
          svc_nxt   = 1'b1;
        end else if (!elig[id_q]) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      SERVICE: begin
        if (ctl.end_routine) begin
          state_nxt = IDLE;
          svc_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        svc_nxt   = 1'b0;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= 1'b0;
      svc_q <= 1'b0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
      svc_q <= svc_nxt;
      id_q  <= id_nxt;
    end
  end

  assign ctl.ifr_out    = ifr_q;
  assign ctl.irq_req    = req_q;
  assign ctl.irq_id     = id_q;
  assign ctl.in_service = svc_q;
endmodule

// File: tb/tb_irq_pending_unit.sv
// Directed bench for irq_pending_unit: a cycle-by-cycle vector table followed
// by hand-written sequences for priority, stable id, simultaneous events and
// reset corner cases.
module tb_irq_pending_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_in, edge_mode, ier_mask, sw_clr;
  logic        global_en;
  int          checks = 0;
  int          errors = 0;

  irq_pending_unit_if #(.NUM_INT(16), .ID_W(4)) bus ();

  irq_pending_unit #(.NUM_INT(16), .ID_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .ier_mask  (ier_mask),
    .global_en (global_en),
    .sw_clr    (sw_clr),
    .ctl       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] irq;
    logic [15:0] em;
    logic        ack;
    logic        eoi;
    logic [15:0] e_ifr;
    logic        e_req;
    logic [3:0]  e_id;
    logic        e_svc;
    logic        chk_id;
  } vec_t;

  vec_t tbl[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_in = '0; sw_clr = '0; edge_mode = 16'hFFFF; ier_mask = 16'hFFFF;
    global_en = 1'b1; bus.ack = 1'b0; bus.end_routine = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // edge line 5: pulse, request, ack, end; then stray ack/end ignored
    tbl[0]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0020, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0020, 1'b1, 4'd5, 1'b0, 1'b1};
    tbl[4]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    // level line 7: request, then level drops with no ack -> withdraw
    tbl[9]  = '{16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[12] = '{16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b1};
    tbl[13] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b1};
    tbl[14] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b1, 4'd7, 1'b0, 1'b1};
    tbl[15] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd7, 1'b0, 1'b1};
    tbl[16] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};

    // reset state
    rst = 1'b1;
    irq_in = 16'hFFFF; sw_clr = '0; edge_mode = 16'hFFFF; ier_mask = 16'hFFFF;
    global_en = 1'b1; bus.ack = 1'b0; bus.end_routine = 1'b0;
    step();
    step();
    chk("rst ifr", 32'(bus.ifr_out), 32'h0);
    chk("rst req", 32'(bus.irq_req), 32'h0);
    chk("rst id",  32'(bus.irq_id), 32'h0);
    chk("rst svc", 32'(bus.in_service), 32'h0);

    // vector table
    do_reset();
    for (int k = 0; k < 17; k++) begin
      irq_in = tbl[k].irq;
      edge_mode = tbl[k].em;
      bus.ack = tbl[k].ack;
      bus.end_routine = tbl[k].eoi;
      step();
      chk($sformatf("v%0d ifr", k), 32'(bus.ifr_out), 32'(tbl[k].e_ifr));
      chk($sformatf("v%0d req", k), 32'(bus.irq_req), 32'(tbl[k].e_req));
      chk($sformatf("v%0d svc", k), 32'(bus.in_service), 32'(tbl[k].e_svc));
      if (tbl[k].chk_id) chk($sformatf("v%0d id", k), 32'(bus.irq_id), 32'(tbl[k].e_id));
    end
    bus.ack = 1'b0; bus.end_routine = 1'b0;

    // priority 3 vs 9, then stable id while line 2 arrives
    do_reset();
    irq_in = 16'h0208; step(); irq_in = '0; step(); step();
    chk("pri ifr", 32'(bus.ifr_out), 32'h0208);
    chk("pri req0", 32'(bus.irq_req), 32'h0);
    step();
    chk("pri req", 32'(bus.irq_req), 32'h1);
    chk("pri id3", 32'(bus.irq_id), 32'd3);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    chk("pri ack svc", 32'(bus.in_service), 32'h1);
    chk("pri ack ifr", 32'(bus.ifr_out), 32'h0200);
    chk("pri ack req", 32'(bus.irq_req), 32'h0);
    bus.end_routine = 1'b1; step(); bus.end_routine = 1'b0;
    chk("pri eoi svc", 32'(bus.in_service), 32'h0);
    chk("pri eoi req", 32'(bus.irq_req), 32'h0);
    step();
    chk("pri next req", 32'(bus.irq_req), 32'h1);
    chk("pri id9", 32'(bus.irq_id), 32'd9);
    irq_in = 16'h0004; step(); irq_in = '0; step(); step();
    chk("stab ifr", 32'(bus.ifr_out), 32'h0204);
    chk("stab id9a", 32'(bus.irq_id), 32'd9);
    step();
    chk("stab id9b", 32'(bus.irq_id), 32'd9);
    chk("stab req", 32'(bus.irq_req), 32'h1);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    chk("stab ack ifr", 32'(bus.ifr_out), 32'h0004);
    bus.end_routine = 1'b1; step(); bus.end_routine = 1'b0; step();
    chk("stab id2", 32'(bus.irq_id), 32'd2);

    // sw_clr vs new edge on line 4 (masked so no request interferes)
    do_reset();
    ier_mask = '0;
    irq_in = 16'h0010; step(); irq_in = '0; step(); step();
    chk("swc set", 32'(bus.ifr_out), 32'h0010);
    step();
    chk("swc masked req", 32'(bus.irq_req), 32'h0);
    sw_clr = 16'h0010; step(); sw_clr = '0;
    chk("swc clear", 32'(bus.ifr_out), 32'h0000);
    irq_in = 16'h0010; step(); irq_in = '0; step();
    sw_clr = 16'h0010; step(); sw_clr = '0;
    chk("swc set wins", 32'(bus.ifr_out), 32'h0010);
    sw_clr = 16'h0010; step(); sw_clr = '0;
    chk("swc clear2", 32'(bus.ifr_out), 32'h0000);

    // level line 6: ack together with withdrawal (global_en low) -> service
    ier_mask = 16'hFFFF; edge_mode = 16'hFFBF;
    irq_in = 16'h0040; step(); step(); step();
    chk("lvl ifr", 32'(bus.ifr_out), 32'h0040);
    step();
    chk("lvl req", 32'(bus.irq_req), 32'h1);
    chk("lvl id6", 32'(bus.irq_id), 32'd6);
    global_en = 1'b0; bus.ack = 1'b1; step(); bus.ack = 1'b0;
    chk("sim svc", 32'(bus.in_service), 32'h1);
    chk("sim req", 32'(bus.irq_req), 32'h0);
    chk("lvl ack keeps", 32'(bus.ifr_out), 32'h0040);
    sw_clr = 16'h0040; step(); sw_clr = '0;
    chk("lvl swc keeps", 32'(bus.ifr_out), 32'h0040);
    global_en = 1'b1; bus.end_routine = 1'b1; step(); bus.end_routine = 1'b0;
    chk("lvl eoi svc", 32'(bus.in_service), 32'h0);
    step();
    chk("lvl rereq", 32'(bus.irq_req), 32'h1);
    chk("lvl reid", 32'(bus.irq_id), 32'd6);

    // reset mid-service with ifr 0x8001, then line held through release
    do_reset();
    irq_in = 16'h8001; step(); irq_in = '0; step(); step();
    chk("rs ifr", 32'(bus.ifr_out), 32'h8001);
    step();
    chk("rs id0", 32'(bus.irq_id), 32'd0);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    chk("rs ack ifr", 32'(bus.ifr_out), 32'h8000);
    irq_in = 16'h0001; step(); irq_in = '0; step(); step();
    chk("rs svc ifr", 32'(bus.ifr_out), 32'h8001);
    chk("rs svc", 32'(bus.in_service), 32'h1);
    irq_in = 16'h0002; rst = 1'b1; step();
    chk("rs after ifr", 32'(bus.ifr_out), 32'h0);
    chk("rs after req", 32'(bus.irq_req), 32'h0);
    chk("rs after id", 32'(bus.irq_id), 32'h0);
    chk("rs after svc", 32'(bus.in_service), 32'h0);
    rst = 1'b0; step();
    chk("rel e0", 32'(bus.ifr_out), 32'h0);
    step();
    chk("rel e1", 32'(bus.ifr_out), 32'h0);
    step();
    chk("rel e2", 32'(bus.ifr_out), 32'h0002);
    step();
    chk("rel req", 32'(bus.irq_req), 32'h1);
    chk("rel id1", 32'(bus.irq_id), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_pending_unit.md
IRQ_PENDING_UNIT -- requirements
Module: irq_pending_unit

Interface
REQ-001 Parameter: NUM_INT, default 16, number of interrupt request lines.
REQ-002 Parameter: ID_W, default 4 ($clog2(NUM_INT)), width of the interrupt index.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: irq_in  input  NUM_INT  raw asynchronous external request lines.
REQ-006 Port: edge_mode  input  NUM_INT  per line: 1 = rising-edge triggered, 0 = level triggered.
REQ-007 Port: ier_mask  input  NUM_INT  per-line enable; bit i = 0 excludes line i from arbitration only.
REQ-008 Port: global_en  input  1  global interrupt enable.
REQ-009 Port: ack  input  1  handler entry; the controller has taken irq_id.
REQ-010 Port: end_routine  input  1  handler return; ends the in-service period.
REQ-011 Port: sw_clr  input  NUM_INT  software clear of edge-pending flags, one bit per line.
REQ-012 Port: ifr_out  output  NUM_INT  pending-flag register, feeds the interrupt controller's flag input.
REQ-013 Port: irq_req  output  1  registered request to the controller.
REQ-014 Port: irq_id  output  ID_W  index of the requested line; valid while irq_req = 1.
REQ-015 Port: in_service  output  1  high from ack until end_routine.

Function
REQ-016 Each irq_in bit SHALL pass a 2-flop synchronizer, plus one history flop for edge detection.
REQ-017 Edge line: ifr_out[i] SHALL set when sync = 1 and history = 0, and stay set until cleared by ack (selected line) or sw_clr[i].
REQ-018 Level line: ifr_out[i] SHALL equal the synchronized level, registered; ack and sw_clr SHALL have no effect on it.
REQ-019 A set and a clear on the same line in the same cycle: set wins.
REQ-020 Latency: irq_in[i] rising before edge N, low before it -> ifr_out[i] = 1 after edge N+2; irq_req = 1 after edge N+3.
REQ-021 Eligible vector = ifr_out & ier_mask, gated by global_en; priority is fixed, lowest index wins.
REQ-022 FSM states: IDLE, REQUEST, SERVICE.
REQ-023 IDLE -> REQUEST when eligible is non-zero; irq_id latches the winner and irq_req goes to 1 on the same edge.
REQ-024 In REQUEST, irq_id SHALL stay stable, including when a higher-priority line becomes pending.
REQ-025 REQUEST -> SERVICE on ack: irq_req goes to 0, in_service goes to 1, and the edge flag of irq_id clears.
REQ-026 REQUEST -> IDLE with no ack if the latched line is no longer eligible (level dropped, sw_clr, mask cleared, global_en low); irq_req goes to 0.
REQ-027 SERVICE -> IDLE on end_routine; in_service goes to 0; the next request is possible at the earliest one edge later.
REQ-028 In SERVICE, no request is issued; new pending flags are captured normally in ifr_out.
REQ-029 ack outside REQUEST and end_routine outside SERVICE SHALL be ignored.
REQ-030 ack and the REQ-026 withdraw condition in the same cycle: ack wins, so the FSM moves to SERVICE.

Reset
REQ-031 While rst = 1 at a clock edge: synchronizer and history flops = 0, ifr_out = 0, FSM = IDLE, irq_req = 0, irq_id = 0, in_service = 0.
REQ-032 Reset mid-REQUEST or mid-SERVICE SHALL abandon the operation; no flag survives.
REQ-033 A line held high through reset release: an edge line SHALL set its flag two edges after release; a level line SHALL follow its level.

Structure
REQ-034 Shared package irq_pkg holds NUM_INT, ID_W and the FSM state enum type.
REQ-035 Sub-module irq_sync: per-line 2-flop synchronizer plus history flop, parameterized by width.
REQ-036 Priority encoder and FSM stay in irq_pending_unit; all outputs come from flops.

Verification
REQ-037 Edge on line 5 (mask all 1, global_en 1), pulse irq_in[5] for 1 cycle before edge 10 -> ifr_out = 0x0020 after edge 12, irq_req = 1 and irq_id = 5 after edge 13; ack -> ifr_out = 0x0000, in_service = 1.
REQ-038 Priority: lines 3 and 9 pending together -> irq_id = 3; ack, end_routine -> irq_id = 9 two edges later.
REQ-039 Stable id: in REQUEST with irq_id = 9, line 2 sets -> irq_id stays 9 until ack.
REQ-040 Level withdraw: level line 7 requested, irq_in[7] drops with no ack -> irq_req = 0 three edges later, FSM = IDLE.
REQ-041 Simultaneous events: sw_clr[4] and a new edge on line 4 in the same cycle -> ifr_out[4] = 1; ack and line withdrawal in the same cycle -> in_service = 1.
REQ-042 Reset mid-SERVICE with ifr_out = 0x8001 -> all outputs 0 after the reset edge.
